// File: rtl/instruction_encoder_if.sv
// Upstream field-set and downstream instruction-byte handshakes of the instruction encoder.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready.
interface instruction_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_sel;
  logic [2:0] in_op;
  logic [3:0] in_imm;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_instr;

  modport master (
    output in_valid, in_sel, in_op, in_imm, out_ready,
    input  in_ready, out_valid, out_instr
  );

  modport slave (
    input  in_valid, in_sel, in_op, in_imm, out_ready,
    output in_ready, out_valid, out_instr
  );
endinterface

// File: rtl/instruction_encoder.sv
// Packs {sel, op, imm} into an instruction byte and buffers it in a small FWFT FIFO
// ahead of the decode stage; flush discards buffered bytes, rst also clears issued_count.
module instruction_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  instruction_encoder_if.slave  bus,
  output logic [ADDR_W:0]       count,
  output logic [7:0]            issued_count
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;

  // in_ready depends on occupancy only, so a full FIFO never passes a byte through.
  assign bus.in_ready  = (count != FULL_COUNT);
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = bus.out_valid ? mem[rd_ptr] : 8'h00;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem[wr_ptr] <= {bus.in_sel, bus.in_op, bus.in_imm};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      issued_count <= 8'h00;
    end else if (flush) begin
      // flush drops a same-cycle push and does not count a same-cycle pop
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        issued_count <= issued_count + 8'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed and randomized checks of instruction_encoder against a queue-based FIFO model.
module tb_instruction_encoder;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [ADDR_W:0]   count;
  logic [7:0]        issued_count;

  instruction_encoder_if bus();

  instruction_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus),
    .count        (count),
    .issued_count (issued_count)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int         model_issued = 0;
  int         vectors      = 0;
  int         miscompares  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b, input bit v, input bit r);
    bus.in_sel    = b[7];
    bus.in_op     = b[6:4];
    bus.in_imm    = b[3:0];
    bus.in_valid  = v;
    bus.out_ready = r;
  endtask

  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    chk("out_valid", {31'd0, bus.out_valid}, (sz != 0) ? 1 : 0);
    chk("out_instr", {24'd0, bus.out_instr}, (sz != 0) ? {24'd0, exp_q[0]} : 0);
    chk("count", {29'd0, count}, sz);
    chk("in_ready", {31'd0, bus.in_ready}, (sz != DEPTH) ? 1 : 0);
    chk("issued_count", {24'd0, issued_count}, model_issued);
  endtask

  // One clock: decide transfers from pre-edge inputs, clock, update model, check.
  task automatic cycle();
    bit         do_push;
    bit         do_pop;
    logic [7:0] b;
    do_push = bus.in_valid && (exp_q.size() < DEPTH);
    do_pop  = bus.out_ready && (exp_q.size() > 0);
    b       = {bus.in_sel, bus.in_op, bus.in_imm};
    if (do_pop && !rst && !flush) chk("pop_data", {24'd0, bus.out_instr}, {24'd0, exp_q[0]});
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      model_issued = 0;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (do_pop) begin
        void'(exp_q.pop_front());
        model_issued = (model_issued + 1) % 256;
      end
      if (do_push) exp_q.push_back(b);
    end
    check_outputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    drive(8'h00, 1'b0, 1'b0);
    cycle();
    cycle();
    chk("reset_out_instr", {24'd0, bus.out_instr}, 32'h00);
    rst = 1'b0;

    // Single push: sel=1 op=010 imm=A packs to 8'hAA
    drive({1'b1, 3'b010, 4'hA}, 1'b1, 1'b0);
    cycle();
    chk("first_byte", {24'd0, bus.out_instr}, 32'hAA);
    drive(8'h00, 1'b0, 1'b1);
    cycle();

    // Fill to full, then a rejected fifth push
    for (int i = 1; i <= 4; i++) begin
      drive(8'(i * 8'h11), 1'b1, 1'b0);
      cycle();
    end
    chk("full_count", {29'd0, count}, 4);
    chk("full_in_ready", {31'd0, bus.in_ready}, 0);
    drive(8'h55, 1'b1, 1'b0);
    cycle();
    chk("full_hold_count", {29'd0, count}, 4);
    chk("full_hold_head", {24'd0, bus.out_instr}, 32'h11);

    // Full with pop: only the pop happens, then simultaneous push+pop
    drive(8'h55, 1'b1, 1'b1);
    cycle();
    chk("full_pop_count", {29'd0, count}, 3);
    cycle();
    chk("push_pop_count", {29'd0, count}, 3);
    drive(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle();

    // Streaming 300 bytes from reset
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(8'($urandom_range(0, 255)), 1'b1, 1'b1);
      cycle();
    end
    drive(8'h00, 1'b0, 1'b1);
    cycle();
    chk("stream_issued_wrap", {24'd0, issued_count}, 32'h2C);

    // Flush with count=3 overrides a push and a pop
    for (int i = 0; i < 3; i++) begin
      drive(8'($urandom_range(0, 255)), 1'b1, 1'b0);
      cycle();
    end
    chk("pre_flush_count", {29'd0, count}, 3);
    flush = 1'b1;
    drive(8'h77, 1'b1, 1'b1);
    cycle();
    flush = 1'b0;
    chk("flush_count", {29'd0, count}, 0);
    chk("flush_out_valid", {31'd0, bus.out_valid}, 0);
    chk("flush_issued", {24'd0, issued_count}, 32'h2C);
    drive(8'h00, 1'b0, 1'b1);
    cycle();

    // Build count=2, issued_count=7, then reset mid-operation
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(8'($urandom_range(0, 255)), 1'b1, 1'b0);
      cycle();
      drive(8'h00, 1'b0, 1'b1);
      cycle();
    end
    for (int i = 0; i < 2; i++) begin
      drive(8'($urandom_range(0, 255)), 1'b1, 1'b0);
      cycle();
    end
    chk("pre_rst_issued", {24'd0, issued_count}, 7);
    chk("pre_rst_count", {29'd0, count}, 2);
    rst = 1'b1;
    drive(8'h00, 1'b0, 1'b0);
    cycle();
    rst = 1'b0;
    chk("rst_issued", {24'd0, issued_count}, 0);
    chk("rst_out_instr", {24'd0, bus.out_instr}, 0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 1);

    // Random traffic with occasional flush
    for (int i = 0; i < 250; i++) begin
      flush = ($urandom_range(0, 19) == 0);
      drive(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cycle();
    end
    flush = 1'b0;
    drive(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
